// File: rtl/morse_char_fifo.sv
// Character FIFO between the UART receiver and the Morse sequencer: filters and
// case-folds raw bytes, collapses spaces, and presents characters first-word-fall-through.
module morse_char_fifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DROP_W     = 8
) (
    input  logic                  clk_24,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [6:0]            rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    // Returns {keep, char}: keep=0 means the byte has no Morse meaning.
    function automatic logic [7:0] filter_byte(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        if (b[7]) begin
            r = 8'h00;
        end else if ((b >= 8'h61) && (b <= 8'h7A)) begin
            r = {1'b1, b[6:0] - 7'h20};
        end else if ((b == 8'h0A) || (b == 8'h0D)) begin
            r = {1'b1, 7'h20};
        end else if ((b < 8'h20) || (b == 8'h7F)) begin
            r = 8'h00;
        end else begin
            r = {1'b1, b[6:0]};
        end
        return r;
    endfunction

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              last_space_q, last_space_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic [6:0]        mem_q [DEPTH];

    logic [7:0]        filt_s;
    logic [6:0]        char_s;
    logic              is_space_s;
    logic              keep_s;
    logic              wr_ok_s;
    logic              rd_ok_s;
    logic              drop_s;
    logic              mem_we_s;

    assign filt_s     = filter_byte(wr_data);
    assign char_s     = filt_s[6:0];
    assign is_space_s = (char_s == 7'h20);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign level      = wr_ptr_q - rd_ptr_q;
    assign drop_count = drop_count_q;
    assign rd_data    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // A pop while full frees the slot being written this same edge, so no drop.
    assign keep_s   = wr_en && filt_s[7] && !(is_space_s && last_space_q);
    assign wr_ok_s  = keep_s && (!full || rd_en);
    assign rd_ok_s  = rd_en && !empty;
    assign drop_s   = keep_s && !wr_ok_s;
    assign mem_we_s = wr_ok_s && !flush && !rst;

    // Next-state computation for pointers, space tracking and the drop counter.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_space_d = last_space_q;
        drop_count_d = drop_count_q;
        if (flush) begin
            rd_ptr_d     = wr_ptr_q;
            last_space_d = 1'b1;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d     = wr_ptr_q + PW'(1);
                last_space_d = is_space_s;
            end else begin
                wr_ptr_d     = wr_ptr_q;
                last_space_d = last_space_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (drop_s && (drop_count_q != {DROP_W{1'b1}})) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end else begin
                drop_count_d = drop_count_q;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_24) begin
        if (rst) begin
            wr_ptr_q     <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            last_space_q <= 1'b1;
            drop_count_q <= {DROP_W{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_space_q <= last_space_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Character storage; contents are deliberately not cleared on reset.
    always_ff @(posedge clk_24) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= char_s;
        end
    end

endmodule

// File: tb/tb_morse_char_fifo.sv
// Directed self-checking bench for morse_char_fifo (DEPTH_LOG2=6, DROP_W=8).
module tb_morse_char_fifo;

    logic        clk_24;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flush;
    logic        rd_en;
    logic [6:0]  rd_data;
    logic        empty;
    logic        full;
    logic [6:0]  level;
    logic [7:0]  drop_count;

    int n_assert = 0;
    int n_fail   = 0;

    morse_char_fifo #(.DEPTH_LOG2(6), .DROP_W(8)) dut (
        .clk_24     (clk_24),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .flush      (flush),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .drop_count (drop_count)
    );

    initial clk_24 = 1'b0;
    always #21 clk_24 = ~clk_24;

    initial begin
        #20000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b, input int gap);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pop_chk(input string tag, input logic [6:0] exp);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        check({tag, "_nempty"}, 32'(empty), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int lvl, input int emp, input int ful, input int drp);
        check({tag, "_level"}, 32'(level), lvl);
        check({tag, "_empty"}, 32'(empty), emp);
        check({tag, "_full"},  32'(full),  ful);
        check({tag, "_drop"},  32'(drop_count), drp);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; rd_en = 1'b0;

        // 1: reset state, then "ab c" with one strobe every 10 cycles
        do_reset();
        chk_state("reset", 0, 1, 0, 0);
        wr(8'h61, 9); wr(8'h62, 9); wr(8'h20, 9); wr(8'h63, 9);
        chk_state("t1_fill", 4, 0, 0, 0);
        pop_chk("t1_p0", 7'h41);
        pop_chk("t1_p1", 7'h42);
        pop_chk("t1_p2", 7'h20);
        pop_chk("t1_p3", 7'h43);
        chk_state("t1_end", 0, 1, 0, 0);

        // 2: line endings and duplicate/leading spaces
        do_reset();
        wr(8'h20, 0); wr(8'h0D, 0); wr(8'h0A, 0); wr(8'h41, 0);
        wr(8'h20, 0); wr(8'h20, 0); wr(8'h0A, 0); wr(8'h42, 0);
        chk_state("t2_fill", 3, 0, 0, 0);
        pop_chk("t2_p0", 7'h41);
        pop_chk("t2_p1", 7'h20);
        pop_chk("t2_p2", 7'h42);
        check("t2_empty", 32'(empty), 32'd1);

        // 3: unsupported bytes are discarded silently
        wr(8'h07, 0); wr(8'h7F, 0); wr(8'h80, 0); wr(8'hC1, 0);
        chk_state("t3", 0, 1, 0, 0);
        wr(8'h7B, 0);
        pop_chk("t3_brace", 7'h7B);

        // 4: overflow, drop counting and write+read while full
        do_reset();
        for (int i = 0; i < 63; i++) wr(8'h41, 0);
        chk_state("t4_63", 63, 0, 0, 0);
        wr(8'h41, 0);
        chk_state("t4_64", 64, 0, 1, 0);
        for (int i = 0; i < 6; i++) wr(8'h41, 0);
        chk_state("t4_70", 64, 0, 1, 6);
        wr_en = 1'b1; wr_data = 8'h41; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_state("t4_wrrd", 64, 0, 1, 6);
        check("t4_head", 32'(rd_data), 32'h41);
        for (int i = 0; i < 260; i++) wr(8'h42, 0);
        check("t4_sat", 32'(drop_count), 32'd255);

        // 5: pointer wrap with order preserved, then underflow guard
        do_reset();
        for (int i = 0; i < 40; i++) wr(8'(8'h21 + i), 0);
        check("t5_lvl40a", 32'(level), 32'd40);
        for (int i = 0; i < 40; i++) pop_chk("t5_pa", 7'(8'h21 + i));
        for (int i = 0; i < 40; i++) wr(8'(8'h30 + i), 0);
        chk_state("t5_wrap", 40, 0, 0, 0);
        wr_en = 1'b1; wr_data = 8'h5A; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("t5_wrrd_lvl", 32'(level), 32'd40);
        for (int i = 1; i < 40; i++) pop_chk("t5_pb", 7'(8'h30 + i));
        pop_chk("t5_pz", 7'h5A);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk_state("t5_under", 0, 1, 0, 0);
        wr_en = 1'b1; wr_data = 8'h45; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("t5_emptywr_lvl", 32'(level), 32'd1);
        check("t5_emptywr_dat", 32'(rd_data), 32'h45);

        // 6: flush keeps drop count, re-arms leading-space suppression
        do_reset();
        for (int i = 0; i < 67; i++) wr(8'h41, 0);
        for (int i = 0; i < 54; i++) begin
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk_state("t6_pre", 10, 0, 0, 3);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h5A; rd_en = 1'b1;
        step();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk_state("t6_flush", 0, 1, 0, 3);
        wr(8'h20, 0);
        chk_state("t6_space", 0, 1, 0, 3);
        wr(8'h51, 0);
        check("t6_q_lvl", 32'(level), 32'd1);
        check("t6_q_dat", 32'(rd_data), 32'h51);

        // Reset mid-stream returns every output to its reset value
        for (int i = 0; i < 70; i++) wr(8'h43, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_state("midrst", 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
